// File: rtl/hist_frame_ctrl.sv
// Frame sequencer for the histogramming core: round-robin merge of two sample
// requesters into the core for frame_len samples, then bin readout tracking.
module hist_frame_ctrl #(
    parameter int DATA_W  = 16,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  frame_len,
    input  logic              req0,
    input  logic [DATA_W-1:0] data0,
    output logic              ack0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data1,
    output logic              ack1,
    output logic [DATA_W-1:0] core_data,
    output logic              core_write_en,
    input  logic              core_ready,
    input  logic              core_valid_out,
    input  logic              core_last_bin,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [CNT_W-1:0]  sample_cnt,
    output logic [CNT_W-1:0]  bin_cnt,
    output logic [2:0]        dbg_state
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ACCUM   = 3'd1,
        S_WAIT_RD = 3'd2,
        S_READOUT = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  len_q;
    logic [CNT_W-1:0]  sample_cnt_q;
    logic [CNT_W-1:0]  sample_cnt_d;
    logic [CNT_W-1:0]  bin_cnt_q;
    logic [CNT_W-1:0]  bin_cnt_d;
    logic [TW-1:0]     wait_cnt_q;
    logic [DATA_W-1:0] core_data_q;
    logic              core_write_en_q;
    logic              rr_q;
    logic              done_q;
    logic              error_q;
    logic              grant;
    logic              pick1;
    logic              final_grant;

    // Handshake: a requester holds reqN high with dataN stable; the sample is
    // consumed in the cycle ackN is high and appears on core_data one cycle later.
    always_comb begin
        grant        = (state_q == S_ACCUM) && core_ready &&
                       (sample_cnt_q < len_q) && (req0 || req1);
        pick1        = req1 && (!req0 || rr_q);
        sample_cnt_d = sample_cnt_q + 1'b1;
        bin_cnt_d    = (&bin_cnt_q) ? bin_cnt_q : bin_cnt_q + 1'b1;
        final_grant  = grant && (sample_cnt_d == len_q);
    end

    assign ack0          = grant && !pick1;
    assign ack1          = grant && pick1;
    assign core_data     = core_data_q;
    assign core_write_en = core_write_en_q;
    assign busy          = (state_q != S_IDLE);
    assign done          = done_q;
    assign error         = error_q;
    assign sample_cnt    = sample_cnt_q;
    assign bin_cnt       = bin_cnt_q;
    assign dbg_state     = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            len_q           <= '0;
            sample_cnt_q    <= '0;
            bin_cnt_q       <= '0;
            wait_cnt_q      <= '0;
            core_data_q     <= '0;
            core_write_en_q <= 1'b0;
            rr_q            <= 1'b0;
            done_q          <= 1'b0;
            error_q         <= 1'b0;
        end else begin
            done_q          <= 1'b0;
            core_write_en_q <= grant;
            if (grant) begin
                core_data_q  <= pick1 ? data1 : data0;
                sample_cnt_q <= sample_cnt_d;
                rr_q         <= !pick1;
            end

            // abort also masks start while idle, so it wins every transition
            if (abort) begin
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            len_q        <= frame_len;
                            sample_cnt_q <= '0;
                            bin_cnt_q    <= '0;
                            error_q      <= 1'b0;
                            if (frame_len == '0) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= S_ACCUM;
                            end
                        end
                    end
                    S_ACCUM: begin
                        if (final_grant) begin
                            state_q    <= S_WAIT_RD;
                            wait_cnt_q <= '0;
                        end
                    end
                    S_WAIT_RD: begin
                        if (core_valid_out) begin
                            bin_cnt_q <= bin_cnt_d;
                            if (core_last_bin) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= S_READOUT;
                            end
                        end else if (wait_cnt_q == TW'(TIMEOUT - 1)) begin
                            error_q <= 1'b1;
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            wait_cnt_q <= wait_cnt_q + 1'b1;
                        end
                    end
                    S_READOUT: begin
                        if (core_valid_out) begin
                            bin_cnt_q <= bin_cnt_d;
                            if (core_last_bin) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    S_DONE:  state_q <= S_IDLE;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule
